// File: rtl/aes_dec_key_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_dec_key_sched_ctrl_if
// Bundles every non-clock signal of the AES-128 decrypt key-schedule
// controller.
//   key_valid / key_ready / key_in : cipher key load handshake.
//   start / abort                  : playback request / synchronous cancel.
//   kg_rc / kg_key / kg_keyout     : link to an external single-round
//                                    KeyGeneration block (combinational).
//   rk_valid / rk_ready / rk_out /
//   rk_round / rk_last             : round keys to the decrypt datapath,
//                                    presented in reverse order (10..0).
//   busy / done                    : status. done is a one-cycle pulse.
// The slave modport is the controller. The master modport is everything
// around it: key source, KeyGeneration instance and decrypt datapath.
// -----------------------------------------------------------------------------
interface aes_dec_key_sched_ctrl_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         start;
  logic         abort;
  logic [3:0]   kg_rc;
  logic [127:0] kg_key;
  logic [127:0] kg_keyout;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;
  logic         done;

  modport slave (
    input  key_valid, key_in, start, abort, kg_keyout, rk_ready,
    output key_ready, kg_rc, kg_key, rk_valid, rk_out, rk_round, rk_last,
           busy, done
  );

  modport master (
    output key_valid, key_in, start, abort, kg_keyout, rk_ready,
    input  key_ready, kg_rc, kg_key, rk_valid, rk_out, rk_round, rk_last,
           busy, done
  );
endinterface

// File: rtl/aes_dec_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_key_sched_ctrl
// Expands an AES-128 cipher key once, using an external single-round
// KeyGeneration block, into an 11-entry round-key store. It then plays the
// schedule back in reverse order (round 10 down to round 0) to a decrypt
// datapath over a valid/ready handshake, as often as start is requested.
// Ports:
//   clk   : single clock, all state on the rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : slave side of aes_dec_key_sched_ctrl_if (key load, KeyGeneration
//           link, round-key stream, start/abort, busy/done).
// Parameter NR is the number of rounds. Only 10 (AES-128) is supported.
// -----------------------------------------------------------------------------
module aes_dec_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes_dec_key_sched_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY,
    S_PLAY
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q [0:NR];
  logic [3:0]   cnt_q;
  logic [3:0]   idx_q;
  logic         done_q;

  // One-cycle control strobes decoded by the FSM for the datapath.
  logic key_load;
  logic expand_step;
  logic play_start;
  logic beat_step;
  logic last_beat;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // abort outranks every other request in the states where it applies.
  // In IDLE it has no effect, so a key offered there is still taken.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d     = state_q;
    key_load    = 1'b0;
    expand_step = 1'b0;
    play_start  = 1'b0;
    beat_step   = 1'b0;
    last_beat   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          key_load = 1'b1;
          state_d  = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          expand_step = 1'b1;
          if (cnt_q == 4'(NR - 1)) state_d = S_READY;
        end
      end
      S_READY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.key_valid) begin
          // A new key replaces the stored schedule; a simultaneous start is
          // dropped rather than queued.
          key_load = 1'b1;
          state_d  = S_EXPAND;
        end else if (bus.start) begin
          play_start = 1'b1;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.rk_ready) begin
          if (idx_q == 4'd0) begin
            last_beat = 1'b1;
            state_d   = S_READY;
          end else begin
            beat_step = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-key store, expansion counter, playback index and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the round-key store is cleared on reset because kg_key shows
      // rk[0] outside expansion and must read zero after reset. A store that
      // never leaks onto an output would normally be left unreset.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_beat;
      if (key_load) begin
        rk_q[0] <= bus.key_in;
        cnt_q   <= '0;
      end
      if (expand_step) begin
        rk_q[cnt_q + 4'd1] <= bus.kg_keyout;
        cnt_q              <= cnt_q + 4'd1;
      end
      if (play_start) idx_q <= 4'(NR);
      if (beat_step)  idx_q <= idx_q - 4'd1;
    end
  end

  // Outputs are decoded from state alone. rk_out and rk_round depend only on
  // idx_q, which moves solely on an accepted beat, so they stay stable while
  // the datapath stalls.
  always_comb begin
    bus.key_ready = (state_q == S_IDLE) || (state_q == S_READY);
    bus.busy      = (state_q == S_EXPAND) || (state_q == S_PLAY);
    bus.done      = done_q;
    bus.kg_rc     = (state_q == S_EXPAND) ? cnt_q : 4'd0;
    bus.kg_key    = (state_q == S_EXPAND) ? rk_q[cnt_q] : rk_q[0];
    bus.rk_valid  = (state_q == S_PLAY);
    bus.rk_out    = (state_q == S_PLAY) ? rk_q[idx_q] : '0;
    bus.rk_round  = (state_q == S_PLAY) ? idx_q : 4'd0;
    bus.rk_last   = (state_q == S_PLAY) && (idx_q == 4'd0);
  end

endmodule

// File: doc/aes_dec_key_sched_ctrl.md
AES_DEC_KEY_SCHED_CTRL -- requirements
Module: aes_dec_key_sched_ctrl

Interface
REQ-001 SHALL have parameter: NR, 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: key_valid  in  1  cipher key offered.
REQ-005 SHALL have port: key_ready  out  1  controller accepts key this cycle.
REQ-006 SHALL have port: key_in  in  128  cipher key (round-0 key).
REQ-007 SHALL have port: start  in  1  request reverse-order playback of the stored schedule.
REQ-008 SHALL have port: abort  in  1  synchronous cancel.
REQ-009 SHALL have port: kg_rc  out  4  round index to the external single-round KeyGeneration instance.
REQ-010 SHALL have port: kg_key  out  128  key input to KeyGeneration.
REQ-011 SHALL have port: kg_keyout  in  128  combinational next-round key from KeyGeneration.
REQ-012 SHALL have port: rk_valid  out  1  round key presented to the decrypt datapath.
REQ-013 SHALL have port: rk_ready  in  1  datapath consumes rk_out.
REQ-014 SHALL have port: rk_out  out  128  round key.
REQ-015 SHALL have port: rk_round  out  4  round number of rk_out (10..0).
REQ-016 SHALL have port: rk_last  out  1  rk_out is round 0.
REQ-017 SHALL have port: busy  out  1  high in EXPAND or PLAY.
REQ-018 SHALL have port: done  out  1  one-cycle pulse after round 0 is consumed.

Function
REQ-019 SHALL implement FSM states IDLE, EXPAND, READY, PLAY; reset state IDLE.
REQ-020 SHALL hold an 11-entry x 128-bit round-key store rk[0..10].
REQ-021 key_ready SHALL be 1 exactly in IDLE and READY.
REQ-022 On key_valid&key_ready: rk[0]<=key_in, counter cnt<=0, go EXPAND.
REQ-023 In EXPAND: kg_rc=cnt, kg_key=rk[cnt]; each cycle rk[cnt+1]<=kg_keyout, cnt<=cnt+1; after writing rk[10] (cnt=9), go READY; expansion takes exactly 10 cycles.
REQ-024 Outside EXPAND, kg_rc SHALL be 0 and kg_key SHALL be rk[0].
REQ-025 In READY, start (with key_valid low) SHALL go PLAY with idx<=10.
REQ-026 In READY, key_valid and start together: key wins, start ignored, go EXPAND (old schedule overwritten).
REQ-027 start in IDLE, EXPAND or PLAY SHALL be ignored (not queued).
REQ-028 In PLAY: rk_valid=1, rk_out=rk[idx], rk_round=idx, rk_last=(idx==0); rk_out/rk_round SHALL remain stable while rk_valid&!rk_ready.
REQ-029 On rk_valid&rk_ready in PLAY: idx>0 -> idx<=idx-1; idx==0 -> go READY and pulse done next cycle.
REQ-030 Schedule SHALL be retained in READY; repeated start replays without re-expansion.
REQ-031 Outside PLAY, rk_valid=0, rk_last=0, rk_round=0, rk_out=0.
REQ-032 abort in EXPAND or PLAY SHALL go IDLE next cycle, no done pulse; abort in READY SHALL go IDLE (schedule invalid); abort in IDLE no effect; abort has priority over key_valid, start, rk_ready.
REQ-033 key_valid during EXPAND/PLAY SHALL not be accepted (key_ready=0).

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, cnt=0, idx=0, all rk entries 0, done=0.
REQ-035 Output values during and immediately after reset: key_ready=1, rk_valid=0, rk_out=0, rk_round=0, rk_last=0, busy=0, done=0, kg_rc=0, kg_key=0.
REQ-036 Reset asserted mid-EXPAND or mid-PLAY SHALL abandon the operation with no done pulse; the schedule is lost.

Verification
REQ-037 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start after READY -> 10 busy EXPAND cycles, then 11 beats: round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, round 1 a0fafe1788542cb123a339392a6c7605, round 0 = key with rk_last=1, one done pulse.
REQ-038 Key 000102030405060708090a0b0c0d0e0f -> first playback beat 13111d7fe3944a17f307a78b4d2b30c5, rk_round=10.
REQ-039 Random rk_ready stalls during PLAY -> rk_out/rk_round held while stalled, 11 accepted beats total, no skipped or repeated round.
REQ-040 key_valid and start same cycle in READY with a new key -> EXPAND entered, no rk_valid until re-expansion complete, next playback uses the new key.
REQ-041 abort at PLAY round 5 -> IDLE next cycle, rk_valid=0, no done; a following start ignored until a new key is expanded.
REQ-042 rst_n pulsed low mid-EXPAND (cnt=4) -> all outputs at reset values immediately, key_ready=1, no done.
